// File: rtl/mem_port_mux.sv
// Shares one memory port among Width masters. The master is chosen by an external round-robin lock arbiter.
// Latency: the request is accepted in IDLE, is issued one cycle later, and the response passes straight through combinationally.
//   The arbiter lock is released after the response, followed by 2 cool-down cycles.
// Backpressure: while mem_req_ready_i is low, ISSUE holds mem_req_valid_o and the registered fields.
//   Only one transaction is outstanding at a time.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o    per-master request handshake; at most one ready bit is set
//   req_we_i/addr/wdata/be     per-master request fields; master i uses slice i
//   rsp_valid_o/rsp_rdata_o    response to the owning master; rdata is 0 when no response
//   grant_i/binary_grant_i     one-hot arbiter grant and its binary index
//   unlock_o                   one-cycle pulse that releases the arbiter lock
//   mem_*                      single memory request/response port
//   busy_o                     high whenever the FSM is not in IDLE
module mem_port_mux #(
  parameter int Width     = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int BeWidth   = DataWidth / 8,
  parameter int BinWidth  = $clog2(Width)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [Width-1:0]           req_valid_i,
  output logic [Width-1:0]           req_ready_o,
  input  logic [Width-1:0]           req_we_i,
  input  logic [Width*AddrWidth-1:0] req_addr_i,
  input  logic [Width*DataWidth-1:0] req_wdata_i,
  input  logic [Width*BeWidth-1:0]   req_be_i,
  output logic [Width-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]       rsp_rdata_o,
  input  logic [Width-1:0]           grant_i,
  input  logic [BinWidth-1:0]        binary_grant_i,
  output logic                       unlock_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic                       mem_we_o,
  output logic [AddrWidth-1:0]       mem_addr_o,
  output logic [DataWidth-1:0]       mem_wdata_o,
  output logic [BeWidth-1:0]         mem_be_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [DataWidth-1:0]       mem_rsp_rdata_i,
  output logic                       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RELEASE,
    COOL
  } state_t;

  state_t state_q, state_d;
  logic   cool_q, cool_d;   // 0 = first COOL cycle, 1 = second

  // Owner and request registers are written only on IDLE acceptance.
  // Later grant changes therefore cannot disturb an in-flight transaction.
  logic [BinWidth-1:0]  owner_q;
  logic                 we_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [BeWidth-1:0]   be_q;
  logic                 load;

  // Mux of the granted master's request. Decoding by comparison keeps an
  // out-of-range binary index, which is possible with a non-power-of-2 Width, harmless.
  logic [Width-1:0]     gnt_onehot;
  logic [Width-1:0]     owner_onehot;
  logic                 sel_valid;
  logic                 sel_we;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;
  logic [BeWidth-1:0]   sel_be;
  logic                 accept;

  always_comb begin
    gnt_onehot   = '0;
    owner_onehot = '0;
    sel_valid    = 1'b0;
    sel_we       = 1'b0;
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_be       = '0;
    for (int i = 0; i < Width; i++) begin
      if (binary_grant_i == BinWidth'(i)) begin
        gnt_onehot[i] = 1'b1;
        sel_valid     = req_valid_i[i];
        sel_we        = req_we_i[i];
        sel_addr      = req_addr_i[i*AddrWidth +: AddrWidth];
        sel_wdata     = req_wdata_i[i*DataWidth +: DataWidth];
        sel_be        = req_be_i[i*BeWidth +: BeWidth];
      end
      if (owner_q == BinWidth'(i)) begin
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // Gating with rst_n keeps req_ready_o at 0 while reset is held.
  // Without it, the IDLE reset state would otherwise allow a combinational accept.
  assign accept = rst_n && (state_q == IDLE) && (|grant_i) && sel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cool_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (load) begin
      owner_q <= binary_grant_i;
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      be_q    <= sel_be;
    end
  end

  always_comb begin
    state_d         = state_q;
    cool_d          = cool_q;
    load            = 1'b0;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    rsp_rdata_o     = '0;
    unlock_o        = 1'b0;
    mem_req_valid_o = 1'b0;
    busy_o          = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (accept) begin
          load        = 1'b1;
          req_ready_o = gnt_onehot;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Any response seen here belongs to no request of ours and is dropped.
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid_i) begin
          rsp_valid_o = owner_onehot;
          rsp_rdata_o = mem_rsp_rdata_i;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        unlock_o = 1'b1;
        cool_d   = 1'b0;
        state_d  = COOL;
      end
      COOL: begin
        // The arbiter takes two cycles to register the unlock and drop its lock.
        // Stale grants seen during that window are ignored.
        if (cool_q) begin
          cool_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cool_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cool_d  = 1'b0;
      end
    endcase
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

endmodule

// File: tb/tb_mem_port_mux.sv
// Directed cycle table for mem_port_mux plus a hand-written mid-transaction reset sequence.
// Each table row gives one cycle of inputs and the outputs expected in that cycle.
module tb_mem_port_mux;

  localparam int W  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    req_valid = '0;
  logic [W-1:0]    req_ready;
  logic [W-1:0]    req_we = '0;
  logic [W*AW-1:0] req_addr = '0;
  logic [W*DW-1:0] req_wdata = '0;
  logic [W*BW-1:0] req_be = '0;
  logic [W-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [W-1:0]    grant = '0;
  logic [1:0]      bin_grant = '0;
  logic            unlock;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [BW-1:0]   mem_be;
  logic            mem_rsp_valid = 1'b0;
  logic [DW-1:0]   mem_rsp_rdata = '0;
  logic            busy;

  mem_port_mux dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .grant_i(grant), .binary_grant_i(bin_grant), .unlock_o(unlock),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_rdata_i(mem_rsp_rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Fixed per-master request payloads
  logic [AW-1:0] m_addr  [W] = '{32'h0000_0040, 32'h0000_0080, 32'h0000_0100, 32'h0000_0200};
  logic [DW-1:0] m_wdata [W] = '{32'h0000_0000, 32'h1111_1111, 32'hDEAD_BEEF, 32'hCAFE_F00D};
  logic [BW-1:0] m_be    [W] = '{4'hF, 4'h3, 4'hF, 4'hC};

  typedef struct {
    logic          rst;
    logic [W-1:0]  valid, we, grant;
    logic [1:0]    bin;
    logic          mrdy, mrsv;
    logic [DW-1:0] mrdata;
    logic [W-1:0]  e_ready, e_rspv;
    logic [DW-1:0] e_rdata;
    logic          e_unlock, e_mreq, e_busy;
    int            chk_mem;   // 0 none, 1 owner's fields, 2 all zero
    int            e_owner;
    logic          e_we;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst, logic [3:0] valid, logic [3:0] we, logic [3:0] gr,
                              logic [1:0] bin, logic mrdy, logic mrsv, logic [31:0] mrdata,
                              logic [3:0] e_ready, logic [3:0] e_rspv, logic [31:0] e_rdata,
                              logic e_unlock, logic e_mreq, logic e_busy,
                              int chk_mem, int e_owner, logic e_we);
    vec_t v;
    v.rst = rst; v.valid = valid; v.we = we; v.grant = gr; v.bin = bin;
    v.mrdy = mrdy; v.mrsv = mrsv; v.mrdata = mrdata;
    v.e_ready = e_ready; v.e_rspv = e_rspv; v.e_rdata = e_rdata;
    v.e_unlock = e_unlock; v.e_mreq = e_mreq; v.e_busy = e_busy;
    v.chk_mem = chk_mem; v.e_owner = e_owner; v.e_we = e_we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    n_vec++;
    chk({tag, " ready"}, 32'(req_ready), 0);
    chk({tag, " rspv"}, 32'(rsp_valid), 0);
    chk({tag, " rdata"}, rsp_rdata, 0);
    chk({tag, " unlock"}, 32'(unlock), 0);
    chk({tag, " mreq"}, 32'(mem_req_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " mwe"}, 32'(mem_we), 0);
    chk({tag, " maddr"}, mem_addr, 0);
    chk({tag, " mwdata"}, mem_wdata, 0);
    chk({tag, " mbe"}, 32'(mem_be), 0);
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.rst; req_valid = v.valid; req_we = v.we; grant = v.grant; bin_grant = v.bin;
    mem_req_ready = v.mrdy; mem_rsp_valid = v.mrsv; mem_rsp_rdata = v.mrdata;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; grant = '0; bin_grant = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin
      req_addr[i*AW +: AW]  = m_addr[i];
      req_wdata[i*DW +: DW] = m_wdata[i];
      req_be[i*BW +: BW]    = m_be[i];
    end

    // rst valid we grant bin mrdy mrsv mrdata | ready rspv rdata unlock mreq busy chk own we
    // Reset is held while master 2 is granted and valid.
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1, 32'h55, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    // Master 2 write: accept in cycle 0, issue in cycle 1, respond in cycle 2, unlock in cycle 3.
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0100, 2, 1, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'hAAAA5555, 0, 4'b0100, 32'hAAAA5555, 0, 0, 1, 1, 2, 1));
    // Grants arriving during RELEASE and COOL are ignored.
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // Cycle 6: back in IDLE; master 0 read is accepted 6 cycles after the previous acceptance.
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0));
    // Memory is not ready for 3 cycles; a response seen during ISSUE is ignored.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'hDDDD, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    // Handshake cycle; a response coincident with ready is ignored.
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'hEEEE, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 4'b0001, 32'h12345678, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // Granted master 1 is not valid: stay IDLE with no ready and no unlock.
    vecs.push_back(mk(1, 4'b1101, 0, 4'b0010, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1101, 0, 4'b0010, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Master 2 read; the grant moves to master 3 mid-transaction.
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 2, 1, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 3, 1, 1, 32'h0BADCAFE, 0, 4'b0100, 32'h0BADCAFE, 0, 0, 1, 1, 2, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 3, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 1));

    @(posedge clk);
    foreach (vecs[k]) begin
      vec_t v;
      string t;
      v = vecs[k];
      @(negedge clk);
      apply(v);
      #1;
      n_vec++;
      t = $sformatf("v%0d", k);
      chk({t, " ready"}, 32'(req_ready), 32'(v.e_ready));
      chk({t, " rspv"}, 32'(rsp_valid), 32'(v.e_rspv));
      chk({t, " rdata"}, rsp_rdata, v.e_rdata);
      chk({t, " unlock"}, 32'(unlock), 32'(v.e_unlock));
      chk({t, " mreq"}, 32'(mem_req_valid), 32'(v.e_mreq));
      chk({t, " busy"}, 32'(busy), 32'(v.e_busy));
      if (v.chk_mem == 1) begin
        chk({t, " mwe"}, 32'(mem_we), 32'(v.e_we));
        chk({t, " maddr"}, mem_addr, m_addr[v.e_owner]);
        chk({t, " mwdata"}, mem_wdata, m_wdata[v.e_owner]);
        chk({t, " mbe"}, 32'(mem_be), 32'(m_be[v.e_owner]));
      end else if (v.chk_mem == 2) begin
        chk({t, " mwe"}, 32'(mem_we), 0);
        chk({t, " maddr"}, mem_addr, 0);
        chk({t, " mwdata"}, mem_wdata, 0);
        chk({t, " mbe"}, 32'(mem_be), 0);
      end
    end

    // Reset during WAIT_RSP, with a response on the bus: outputs clear
    // at once, and no response or unlock is produced.
    @(posedge clk);
    #2;
    idle_inputs();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h7777_7777;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    chk_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    chk_all_zero("rst_release");
    @(negedge clk);
    chk_all_zero("post_rst_idle");
    // A new grant is accepted from IDLE.
    grant = 4'b0010; bin_grant = 2'd1; req_valid = 4'b0010; req_we = 4'b0010;
    mem_req_ready = 1'b1;
    #1;
    n_vec++;
    chk("post_rst accept ready", 32'(req_ready), 32'h2);
    chk("post_rst accept unlock", 32'(unlock), 0);
    @(negedge clk);
    idle_inputs();
    mem_req_ready = 1'b1;
    #1;
    n_vec++;
    chk("post_rst issue mreq", 32'(mem_req_valid), 1);
    chk("post_rst issue maddr", mem_addr, m_addr[1]);
    chk("post_rst issue mwdata", mem_wdata, m_wdata[1]);
    chk("post_rst issue mbe", 32'(mem_be), 32'(m_be[1]));
    chk("post_rst issue mwe", 32'(mem_we), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
